regfile_flags: RTL and testbench
================================

// Module: regfile_flags
// PURPOSE
//   Operand register file and status-flag register around the 4-bit ALU.
//   Upstream: two combinational read ports drive ALU operands A and B.
//   Downstream: captures ALU result R into the destination register and latches z/c/s.
//   Latched flags feed conditional jumps in the control unit.
// PARAMETERS
//   WIDTH   4   data width; equals ALU operand/result width
//   NREGS   16  number of registers; address width AW = $clog2(NREGS) = 4
// PORTS
//   clk      in   1      single clock; all state updates on posedge
//   reset    in   1      synchronous reset, active-low (reset==0 at posedge clears state)
//   ra1      in   AW     read address, port 1 (ALU operand A)
//   ra2      in   AW     read address, port 2 (ALU operand B)
//   rd1      out  WIDTH  read data, port 1
//   rd2      out  WIDTH  read data, port 2
//   we3      in   1      register write enable
//   wa3      in   AW     write address
//   wd3      in   WIDTH  write data (ALU R)
//   fl_we    in   1      flag register update enable
//   arit     in   1      1 = arithmetic op (update z,c,s); 0 = logic op (update z only)
//   z_in     in   1      ALU zero flag
//   c_in     in   1      ALU carry flag (X during logic ops; must not be sampled then)
//   s_in     in   1      ALU sign flag (X during logic ops; must not be sampled then)
//   z_q      out  1      latched zero flag
//   c_q      out  1      latched carry flag
//   s_q      out  1      latched sign flag
// BEHAVIOUR
//   Reset:
//   - reset==0 at posedge: all NREGS registers <= 0; z_q, c_q, s_q <= 0.
//   - Reset overrides we3/fl_we in the same cycle.
//   - Reset asserted mid-write: the write is dropped.
//   Register 0:
//   - Hardwired to zero; writes to wa3==0 are ignored.
//   - Reads of address 0 return 0 regardless of bypass.
//   Read ports:
//   - Combinational, zero latency: rd1 = reg[ra1], rd2 = reg[ra2].
//   Write port:
//   - we3=1 at posedge: reg[wa3] <= wd3; result visible one cycle later.
//   Write-through bypass:
//   - Condition: we3=1, reset=1, wa3!=0, raN==wa3.
//   - Then rdN = wd3 in the same cycle. Applies to both ports independently.
//   - ra1==ra2==wa3 gives both ports wd3.
//   Flags:
//   - fl_we=1 and arit=1: z_q<=z_in, c_q<=c_in, s_q<=s_in.
//   - fl_we=1 and arit=0: z_q<=z_in; c_q and s_q hold.
//   - fl_we=0: all flags hold.
//   - X on c_in/s_in while arit=0 must never propagate to c_q/s_q.
//   Independence:
//   - Register and flag writes are independent; both may occur in one cycle.
//   Widths:
//   - No arithmetic here. Addresses are full range 0..NREGS-1; no wrap or out-of-range case.
// STRUCTURE
//   Shared package/header `cpu_defs`: WIDTH, AW, NREGS, flag index constants
//   (FL_Z=0, FL_C=1, FL_S=2).
//   One sub-module `flag_reg`: 3-bit register with per-bit enables built from fl_we/arit.
//   Register array, read muxes and bypass live in regfile_flags.
// TESTING
//   1. reset=0 one edge after random writes -> rd1=rd2=0 for all ra; z_q=c_q=s_q=0.
//   2. we3=1, wa3=5, wd3=4'hA; next cycle ra1=5 -> rd1=4'hA. wa3=0, wd3=4'hF -> rd of 0 stays 0.
//   3. Bypass: we3=1, wa3=3, wd3=4'h7, ra1=ra2=3 in same cycle -> rd1=rd2=4'h7 before the edge.
//   4. Flags: fl_we=1, arit=1, z,c,s=0,1,1 -> z_q,c_q,s_q=0,1,1.
//      Then arit=0, z_in=1, c_in=s_in=X -> z_q=1, c_q=1, s_q=1 (no X).
//   5. fl_we=0 with changing z/c/s inputs -> flags hold. reset=0 together with we3=1 -> write dropped.
//   6. Full sweep: write i+1 to regs 1..15, read all pairs (ra1,ra2) -> self-checking count, 0 errors.

Source files
------------

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs
//   Shared definitions for the 4-bit datapath: data/address widths, register
//   count, and the bit positions of the status flags inside the packed flag
//   vector. Also provides the helper that turns the ALU-side control
//   (fl_we, arit) into per-flag write enables.
//
//   Contents:
//     WIDTH, NREGS, AW   datapath width, register count, address width
//     FL_Z, FL_C, FL_S   flag bit positions (zero, carry, sign)
//     NFLAGS             number of latched flags
//     data_t, addr_t     register data / register address types
//     flags_t            packed flag vector, indexed with FL_*
//     flag_enables()     per-flag enables from fl_we/arit
// ---------------------------------------------------------------------------
package cpu_defs;

    localparam int WIDTH  = 4;
    localparam int NREGS  = 16;
    localparam int AW     = $clog2(NREGS);

    localparam int FL_Z   = 0;
    localparam int FL_C   = 1;
    localparam int FL_S   = 2;
    localparam int NFLAGS = 3;

    typedef logic [WIDTH-1:0]  data_t;
    typedef logic [AW-1:0]     addr_t;
    typedef logic [NFLAGS-1:0] flags_t;

    // Logic ops only produce a meaningful zero flag; carry and sign coming
    // out of the ALU are undefined then, so their enables require arit.
    function automatic flags_t flag_enables(input logic fl_we, input logic arit);
        flags_t en;
        en        = '0;
        en[FL_Z]  = fl_we;
        en[FL_C]  = fl_we & arit;
        en[FL_S]  = fl_we & arit;
        return en;
    endfunction

endpackage

// File: rtl/flag_reg.sv
// ---------------------------------------------------------------------------
// flag_reg
//   Status-flag register (z, c, s) with an individual enable per bit. The
//   enables are derived from fl_we and arit so that a logic operation only
//   refreshes the zero flag and leaves carry/sign untouched.
//
//   Ports:
//     clk     in   1       clock, all updates on posedge
//     reset   in   1       synchronous reset, active-low; clears all flags
//     fl_we   in   1       flag update enable
//     arit    in   1       1 = arithmetic op (all flags), 0 = logic op (z only)
//     d       in   NFLAGS  incoming ALU flags, indexed with FL_*
//     q       out  NFLAGS  latched flags, indexed with FL_*
// ---------------------------------------------------------------------------
module flag_reg
    import cpu_defs::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   fl_we,
    input  logic   arit,
    input  flags_t d,
    output flags_t q
);

    flags_t en;

    always_comb begin
        en = flag_enables(fl_we, arit);
    end

    // A bit whose enable is low is never sampled, so an undefined carry or
    // sign input during a logic op cannot leak into the stored flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            for (int i = 0; i < NFLAGS; i++) begin
                if (en[i]) begin
                    q[i] <= d[i];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_flags.sv
// ---------------------------------------------------------------------------
// regfile_flags
//   Operand register file and status-flag register around the 4-bit ALU.
//   Two combinational read ports supply ALU operands A and B; the write port
//   captures the ALU result, and the flag register latches z/c/s for the
//   control unit's conditional jumps. Register 0 reads as zero and ignores
//   writes. A write in flight is forwarded to any read port addressing the
//   same register in the same cycle (write-through bypass).
//
//   Ports:
//     clk     in   1      clock, all state updates on posedge
//     reset   in   1      synchronous reset, active-low; clears regs and flags
//     ra1     in   AW     read address port 1 (operand A)
//     ra2     in   AW     read address port 2 (operand B)
//     rd1     out  WIDTH  read data port 1
//     rd2     out  WIDTH  read data port 2
//     we3     in   1      register write enable
//     wa3     in   AW     write address
//     wd3     in   WIDTH  write data (ALU result)
//     fl_we   in   1      flag update enable
//     arit    in   1      1 = arithmetic op (z,c,s), 0 = logic op (z only)
//     z_in    in   1      ALU zero flag
//     c_in    in   1      ALU carry flag (undefined during logic ops)
//     s_in    in   1      ALU sign flag (undefined during logic ops)
//     z_q     out  1      latched zero flag
//     c_q     out  1      latched carry flag
//     s_q     out  1      latched sign flag
// ---------------------------------------------------------------------------
module regfile_flags
    import cpu_defs::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we3,
    input  logic [AW-1:0]     wa3,
    input  logic [WIDTH-1:0]  wd3,
    input  logic              fl_we,
    input  logic              arit,
    input  logic              z_in,
    input  logic              c_in,
    input  logic              s_in,
    output logic              z_q,
    output logic              c_q,
    output logic              s_q
);

    // -----------------------------------------------------------------------
    // Register array
    // -----------------------------------------------------------------------
    data_t mem [NREGS];

    // Entry 0 is cleared by reset and never written afterwards; the read
    // muxes additionally force address 0 to zero.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we3 && (wa3 != '0)) begin
            mem[wa3] <= wd3;
        end
    end

    // -----------------------------------------------------------------------
    // Read ports with write-through bypass
    // -----------------------------------------------------------------------
    // Forwarding is only legal when the write will actually commit at the
    // coming edge: reset deasserted and a non-zero destination.
    logic bypass_ok;

    always_comb begin
        bypass_ok = we3 && reset && (wa3 != '0);
    end

    always_comb begin
        rd1 = mem[ra1];
        if (bypass_ok && (ra1 == wa3)) begin
            rd1 = wd3;
        end
        if (ra1 == '0) begin
            rd1 = '0;
        end
    end

    always_comb begin
        rd2 = mem[ra2];
        if (bypass_ok && (ra2 == wa3)) begin
            rd2 = wd3;
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Status flags
    // -----------------------------------------------------------------------
    flags_t flag_d;
    flags_t flag_q;

    always_comb begin
        flag_d       = '0;
        flag_d[FL_Z] = z_in;
        flag_d[FL_C] = c_in;
        flag_d[FL_S] = s_in;
    end

    flag_reg u_flag_reg (
        .clk   (clk),
        .reset (reset),
        .fl_we (fl_we),
        .arit  (arit),
        .d     (flag_d),
        .q     (flag_q)
    );

    always_comb begin
        z_q = flag_q[FL_Z];
        c_q = flag_q[FL_C];
        s_q = flag_q[FL_S];
    end

endmodule

// File: tb/tb_regfile_flags.sv
// ---------------------------------------------------------------------------
// tb_regfile_flags
//   Directed bench for regfile_flags. Drivers change inputs 1 time unit after
//   posedge and push the hand-computed expected response; the monitor drains
//   the expected queue on every negedge and compares against the DUT.
//   Queue entry layout: {rd1, rd2, z, c, s}; the mask selects which part
//   (bit0 = read data, bit1 = flags) is compared.
// ---------------------------------------------------------------------------
module tb_regfile_flags;
    import cpu_defs::*;

    localparam int W = 2*WIDTH + NFLAGS;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic  reset;
    addr_t ra1, ra2, wa3;
    data_t rd1, rd2, wd3;
    logic  we3, fl_we, arit, z_in, c_in, s_in;
    logic  z_q, c_q, s_q;

    regfile_flags dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .fl_we (fl_we),
        .arit  (arit),
        .z_in  (z_in),
        .c_in  (c_in),
        .s_in  (s_in),
        .z_q   (z_q),
        .c_q   (c_q),
        .s_q   (s_q)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [1:0]   mask_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;
    data_t        model [NREGS];

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [1:0]   m;
        string        n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            n = name_q.pop_front();
            if (m[0]) begin
                checks++;
                if ({rd1, rd2} !== e[W-1:NFLAGS]) begin
                    errors++;
                    $display("FAIL %s: rd1=%h rd2=%h expected rd1=%h rd2=%h (ra1=%0d ra2=%0d)",
                             n, rd1, rd2, e[W-1 -: WIDTH], e[W-1-WIDTH -: WIDTH], ra1, ra2);
                end
            end
            if (m[1]) begin
                checks++;
                if ({z_q, c_q, s_q} !== e[NFLAGS-1:0]) begin
                    errors++;
                    $display("FAIL %s: zcs=%b expected zcs=%b", n, {z_q, c_q, s_q}, e[NFLAGS-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string n, input logic [1:0] m,
                              input data_t e1, input data_t e2, input logic [2:0] zcs);
        exp_q.push_back({e1, e2, zcs});
        mask_q.push_back(m);
        name_q.push_back(n);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
    endtask

    task automatic write_reg(input addr_t a, input data_t d);
        we3 = 1'b1;
        wa3 = a;
        wd3 = d;
        tick();
        we3 = 1'b0;
        if (a != '0) model[a] = d;
    endtask

    task automatic check_read_exp(input string n, input addr_t a1, input addr_t a2,
                                  input data_t e1, input data_t e2);
        ra1 = a1;
        ra2 = a2;
        expect_now(n, 2'b01, e1, e2, 3'b000);
        tick();
    endtask

    task automatic check_read(input string n, input addr_t a1, input addr_t a2);
        check_read_exp(n, a1, a2, model[a1], model[a2]);
    endtask

    task automatic check_flags(input string n, input logic [2:0] zcs);
        expect_now(n, 2'b10, '0, '0, zcs);
        tick();
    endtask

    task automatic set_flags_in(input logic en, input logic ar,
                                input logic z, input logic c, input logic s);
        fl_we = en;
        arit  = ar;
        z_in  = z;
        c_in  = c;
        s_in  = s;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0; we3 = 1'b0;
        set_flags_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        clear_model();
        tick();
        tick();

        // Reset state: everything reads zero
        ra1 = 4'd5;
        ra2 = 4'd15;
        expect_now("reset_state", 2'b11, 4'h0, 4'h0, 3'b000);
        tick();
        reset = 1'b1;

        // Random writes with all flags set, then one reset edge clears all
        set_flags_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            write_reg(addr_t'($urandom_range(1, NREGS-1)), data_t'($urandom_range(1, 15)));
            fl_we = 1'b0;
        end
        check_flags("flags_before_reset", 3'b111);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        clear_model();
        for (int i = 0; i < NREGS; i++) begin
            check_read_exp("reset_clears_regs", addr_t'(i), addr_t'(NREGS-1-i), 4'h0, 4'h0);
        end
        check_flags("reset_clears_flags", 3'b000);

        // Basic write/read, register 0 hardwired
        write_reg(4'd5, 4'hA);
        check_read_exp("write_then_read", 4'd5, 4'd0, 4'hA, 4'h0);
        write_reg(4'd0, 4'hF);
        check_read_exp("reg0_ignores_write", 4'd0, 4'd5, 4'h0, 4'hA);

        // Bypass: both ports, reg3 holds 0 so 7 can only come from forwarding
        we3 = 1'b1; wa3 = 4'd3; wd3 = 4'h7; ra1 = 4'd3; ra2 = 4'd3;
        expect_now("bypass_both_ports", 2'b01, 4'h7, 4'h7, 3'b000);
        tick();
        we3 = 1'b0;
        model[3] = 4'h7;

        write_reg(4'd9, 4'h2);
        we3 = 1'b1; wa3 = 4'd9; wd3 = 4'hC; ra1 = 4'd9; ra2 = 4'd3;
        expect_now("bypass_port1_only", 2'b01, 4'hC, 4'h7, 3'b000);
        tick();
        model[9] = 4'hC;
        we3 = 1'b1; wa3 = 4'd9; wd3 = 4'h4; ra1 = 4'd3; ra2 = 4'd9;
        expect_now("bypass_port2_only", 2'b01, 4'h7, 4'h4, 3'b000);
        tick();
        model[9] = 4'h4;
        we3 = 1'b1; wa3 = 4'd0; wd3 = 4'hF; ra1 = 4'd0; ra2 = 4'd0;
        expect_now("no_bypass_to_reg0", 2'b01, 4'h0, 4'h0, 3'b000);
        tick();
        we3 = 1'b0;
        check_read_exp("after_bypass_writes", 4'd9, 4'd3, 4'h4, 4'h7);

        // Flags: arithmetic updates all, logic updates z only
        set_flags_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        fl_we = 1'b0;
        check_flags("arit_flags_011", 3'b011);
        set_flags_in(1'b1, 1'b0, 1'b1, 1'bx, 1'bx);
        tick();
        fl_we = 1'b0;
        check_flags("logic_flags_z_only_111", 3'b111);
        set_flags_in(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        fl_we = 1'b0;
        check_flags("arit_flags_001", 3'b001);
        set_flags_in(1'b1, 1'b0, 1'b1, 1'bx, 1'bx);
        tick();
        fl_we = 1'b0;
        check_flags("logic_flags_z_only_101", 3'b101);

        // Flags hold while fl_we=0 regardless of inputs
        for (int i = 0; i < 4; i++) begin
            set_flags_in(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end
        check_flags("flags_hold", 3'b101);

        // Register and flag write in the same cycle
        we3 = 1'b1; wa3 = 4'd12; wd3 = 4'h6;
        set_flags_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        we3 = 1'b0;
        fl_we = 1'b0;
        model[12] = 4'h6;
        ra1 = 4'd12; ra2 = 4'd0;
        expect_now("reg_and_flag_same_cycle", 2'b11, 4'h6, 4'h0, 3'b100);
        tick();

        // Reset wins over a concurrent write and flag update; no bypass then
        write_reg(4'd6, 4'h2);
        reset = 1'b0;
        we3 = 1'b1; wa3 = 4'd6; wd3 = 4'h9; ra1 = 4'd6; ra2 = 4'd12;
        set_flags_in(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_now("no_bypass_during_reset", 2'b01, 4'h2, 4'h6, 3'b000);
        tick();
        reset = 1'b1;
        we3 = 1'b0;
        fl_we = 1'b0;
        clear_model();
        check_read_exp("reset_drops_write", 4'd6, 4'd12, 4'h0, 4'h0);
        check_flags("reset_beats_flag_write", 3'b000);

        // Full sweep: reg i holds i+1, every address pair read
        for (int i = 1; i < NREGS; i++) begin
            write_reg(addr_t'(i), data_t'(i + 1));
        end
        for (int a = 0; a < NREGS; a++) begin
            for (int b = 0; b < NREGS; b++) begin
                check_read("sweep", addr_t'(a), addr_t'(b));
            end
        end

        // ---------------- final report ----------------
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
